labfinalsoc_onchip_memory_dp: RTL and testbench
===============================================

LABFINALSOC_ONCHIP_MEMORY_DP -- requirements
Module: labfinalsoc_onchip_memory_dp

Interface
- REQ-001 The block SHALL have these parameters:
  - DATA_W, 32: data width; multiple of 8.
  - DEPTH, 16: number of words; 2 to 65536; need not be a power of two.
  - READ_LATENCY, 1: cycles from accepted read to readdatavalid; legal values 1 or 2.
  - INIT_FILE, "labfinalsoc_onchip_memory_dp.hex": power-up contents.
- REQ-002 Derived widths: AW = clog2(DEPTH); BE = DATA_W/8.
- REQ-003 The block SHALL have these ports; N = 1, 2 (two identical Avalon-MM slave ports s1, s2):
  - clk  in  1  single clock for everything.
  - reset_n  in  1  reset; asynchronous assert, active-low.
  - sN_address  in  AW  word address.
  - sN_chipselect  in  1  port select.
  - sN_read  in  1  read request.
  - sN_write  in  1  write request.
  - sN_byteenable  in  BE  per-byte write enable.
  - sN_writedata  in  DATA_W  write data.
  - sN_clken  in  1  per-port clock enable.
  - sN_readdata  out  DATA_W  read data.
  - sN_readdatavalid  out  1  one-cycle read-data qualifier.
  - freeze  in  1  global write inhibit.

Function
- REQ-004 A port SHALL accept a request on a rising clk edge when chipselect=1 and clken=1; no waitrequest; one request per port per cycle.
- REQ-005 Accepted write, freeze=0: each byte with byteenable[i]=1 at an in-range address SHALL be updated at that edge.
- REQ-006 Accepted read with write=0: readdatavalid SHALL pulse high for exactly one cycle, READ_LATENCY cycles after acceptance, with the addressed word on readdata.
- REQ-007 Back-to-back reads SHALL be fully pipelined: one readdatavalid per accepted read, in order, with no gaps.
- REQ-008 read=1 and write=1 together SHALL be treated as a write only; no readdatavalid results.
- REQ-009 Read-during-write, same port or cross port, same address, same edge: the read SHALL return the old data.
- REQ-010 Both ports writing the same address on the same edge:
  - bytes enabled on both ports take s1 data;
  - bytes enabled on one port only take that port's data.
- REQ-011 freeze=1 SHALL suppress all memory updates on both ports; reads and pipelines continue normally.
- REQ-012 Address >= DEPTH: writes ignored; reads return all-zero data with a normal readdatavalid.
- REQ-013 sN_clken=0 SHALL stall port N's read pipeline:
  - no acceptance, no stage advance;
  - readdata and readdatavalid hold their values.
  - The other port is unaffected.
- REQ-014 readdata SHALL hold the last valid data between valid pulses.

Reset
- REQ-015 While reset_n=0, all sN_readdatavalid = 0, all sN_readdata = 0, and all pipeline valid stages SHALL be cleared.
- REQ-016 Reads in flight at reset assertion SHALL be discarded; no readdatavalid for them after release.
- REQ-017 Memory contents SHALL NOT be altered by reset; INIT_FILE is loaded at configuration only.
- REQ-018 reset_n deassertion SHALL be synchronised internally; the first request is accepted on the second rising edge after release.

Structure
- REQ-019 A shared package labfinalsoc_mem_pkg SHALL hold:
  - clog2 function;
  - legal READ_LATENCY constants;
  - the out-of-range read value constant.
- REQ-020 Storage SHALL be a single inferred true-dual-port array with byte-lane write enables; no vendor primitive.
- REQ-021 Per-port read latency, valid tracking and clken stall SHALL live in sub-module labfinalsoc_mem_rdpipe, instantiated once per port.
- REQ-022 Parameter checks (DATA_W%8, READ_LATENCY, DEPTH range) SHALL be elaboration-time errors.

Verification (DATA_W=32, DEPTH=16, READ_LATENCY=2)
- REQ-023 Byte-enable write:
  - s1 writes 0xA5A5A5A5 to addr 3 (BE=1111), then 0x000000FF to addr 3 with BE=0001;
  - s2 reads addr 3 -> readdatavalid 2 cycles later, readdata = 0xA5A5A5FF.
- REQ-024 Collision and streaming:
  - same edge: s1 writes 0x11111111 (BE=0011) and s2 writes 0x22222222 (BE=1110) to addr 5;
  - read addr 5 -> 0x22221111;
  - 4 back-to-back reads of addr 0-3 -> 4 consecutive valid pulses, in order.
- REQ-025 Read-during-write: addr 7 holds 0xDEADBEEF; s1 writes 0x0 to addr 7 while s2 reads addr 7 -> s2 gets 0xDEADBEEF; a following read gets 0x0.
- REQ-026 Freeze and range: freeze=1, s1 writes 0x12345678 to addr 2 -> addr 2 unchanged; write to addr 20 (DEPTH=20, AW=5 build) ignored; read addr 20 -> 0x00000000 with valid.
- REQ-027 Stall and reset:
  - s1_clken=0 for 3 cycles mid-stream -> valid delayed by exactly 3 cycles, data intact, s2 unaffected;
  - reset_n low one cycle after a read -> no valid pulse, readdata = 0.

Source files
------------

// File: rtl/labfinalsoc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : labfinalsoc_mem_pkg
// Description : Shared constants and helpers for the dual-port on-chip memory.
// Revision    : 1.0 - initial release
// ============================================================================
package labfinalsoc_mem_pkg;

    localparam int         c_RD_LAT_MIN = 1;
    localparam int         c_RD_LAT_MAX = 2;
    // Byte pattern returned for reads beyond DEPTH; replicated per lane.
    localparam logic [7:0] c_OOR_BYTE   = 8'h00;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/labfinalsoc_mem_rdpipe.sv
`default_nettype none
// ============================================================================
// Module      : labfinalsoc_mem_rdpipe
// Description : Per-port read-data pipeline with valid tracking and clken stall.
// Revision    : 1.0 - initial release
// ============================================================================
module labfinalsoc_mem_rdpipe #(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clken,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [READ_LATENCY-1:0] r_vld;
    logic [DATA_W-1:0]       r_dat [READ_LATENCY];

    // Data stages only load behind a valid, so the last stage keeps the most
    // recent returned word between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_dat[k] <= '0;
            end
        end else if (i_clken) begin
            r_vld[0] <= i_req;
            if (i_req) begin
                r_dat[0] <= i_data;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign o_valid = r_vld[READ_LATENCY-1];
    assign o_data  = r_dat[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/labfinalsoc_onchip_memory_dp.sv
`default_nettype none
// ============================================================================
// Module      : labfinalsoc_onchip_memory_dp
// Description : True dual-port byte-writable on-chip RAM, two Avalon-MM slaves.
// Revision    : 1.0 - initial release
// ============================================================================
module labfinalsoc_onchip_memory_dp
    import labfinalsoc_mem_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 16,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "labfinalsoc_onchip_memory_dp.hex",
    localparam int   AW           = clog2(DEPTH),
    localparam int   BE           = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     s1_address,
    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [BE-1:0]     s1_byteenable,
    input  logic [DATA_W-1:0] s1_writedata,
    input  logic              s1_clken,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    input  logic [AW-1:0]     s2_address,
    input  logic              s2_chipselect,
    input  logic              s2_read,
    input  logic              s2_write,
    input  logic [BE-1:0]     s2_byteenable,
    input  logic [DATA_W-1:0] s2_writedata,
    input  logic              s2_clken,
    output logic [DATA_W-1:0] s2_readdata,
    output logic              s2_readdatavalid,
    input  logic              freeze
);

    if (((DATA_W % 8) != 0) || (DATA_W < 8)) begin : g_chk_data_w
        $error("DATA_W must be a non-zero multiple of 8");
    end
    if ((DEPTH < 2) || (DEPTH > 65536)) begin : g_chk_depth
        $error("DEPTH must lie in 2..65536");
    end
    if ((READ_LATENCY < c_RD_LAT_MIN) || (READ_LATENCY > c_RD_LAT_MAX)) begin : g_chk_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    // Power-up contents come from the configuration image, so a name is mandatory.
    if (INIT_FILE == "") begin : g_chk_init_file
        $error("INIT_FILE must name the power-up image");
    end

    localparam logic [AW:0] c_DEPTH_LIM = (AW + 1)'(DEPTH);

    logic              r_run;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_s1_in_range, w_s2_in_range;
    logic              w_s1_acc, w_s2_acc;
    logic              w_s1_wr, w_s2_wr;
    logic              w_s1_rd, w_s2_rd;
    logic [DATA_W-1:0] w_s1_rdata, w_s2_rdata;

    // Single release stage: requests are first honoured on the second edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_s1_in_range = ({1'b0, s1_address} < c_DEPTH_LIM);
    assign w_s2_in_range = ({1'b0, s2_address} < c_DEPTH_LIM);
    assign w_s1_acc      = s1_chipselect & s1_clken & r_run;
    assign w_s2_acc      = s2_chipselect & s2_clken & r_run;
    assign w_s1_wr       = w_s1_acc & s1_write & w_s1_in_range & ~freeze;
    assign w_s2_wr       = w_s2_acc & s2_write & w_s2_in_range & ~freeze;
    assign w_s1_rd       = w_s1_acc & s1_read & ~s1_write;
    assign w_s2_rd       = w_s2_acc & s2_read & ~s2_write;

    // s1 lane is assigned last so it wins bytes that both ports enable.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE; b++) begin
            if (w_s2_wr && s2_byteenable[b]) begin
                r_mem[s2_address][8*b +: 8] <= s2_writedata[8*b +: 8];
            end
            if (w_s1_wr && s1_byteenable[b]) begin
                r_mem[s1_address][8*b +: 8] <= s1_writedata[8*b +: 8];
            end
        end
    end

    assign w_s1_rdata = w_s1_in_range ? r_mem[s1_address] : {BE{c_OOR_BYTE}};
    assign w_s2_rdata = w_s2_in_range ? r_mem[s2_address] : {BE{c_OOR_BYTE}};

    labfinalsoc_mem_rdpipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_s1 (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_clken (s1_clken),
        .i_req   (w_s1_rd),
        .i_data  (w_s1_rdata),
        .o_data  (s1_readdata),
        .o_valid (s1_readdatavalid)
    );

    labfinalsoc_mem_rdpipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe_s2 (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_clken (s2_clken),
        .i_req   (w_s2_rd),
        .i_data  (w_s2_rdata),
        .o_data  (s2_readdata),
        .o_valid (s2_readdatavalid)
    );

endmodule
`default_nettype wire

// File: tb/tb_labfinalsoc_onchip_memory_dp.sv
`default_nettype none
// ============================================================================
// Module      : tb_labfinalsoc_onchip_memory_dp
// Description : Self-checking bench for the dual-port on-chip memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_labfinalsoc_onchip_memory_dp;

    localparam int DEPTH = 20;
    localparam int RL    = 2;
    localparam int AW    = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [AW-1:0] s1_address, s2_address;
    logic        s1_chipselect, s2_chipselect, s1_read, s2_read, s1_write, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic        s1_clken, s2_clken, s1_readdatavalid, s2_readdatavalid;
    logic        freeze;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    labfinalsoc_onchip_memory_dp #(
        .DATA_W       (32),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL),
        .INIT_FILE    ("labfinalsoc_onchip_memory_dp.hex")
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s1_address       (s1_address),
        .s1_chipselect    (s1_chipselect),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_byteenable    (s1_byteenable),
        .s1_writedata     (s1_writedata),
        .s1_clken         (s1_clken),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .s2_address       (s2_address),
        .s2_chipselect    (s2_chipselect),
        .s2_read          (s2_read),
        .s2_write         (s2_write),
        .s2_byteenable    (s2_byteenable),
        .s2_writedata     (s2_writedata),
        .s2_clken         (s2_clken),
        .s2_readdata      (s2_readdata),
        .s2_readdatavalid (s2_readdatavalid),
        .freeze           (freeze)
    );

    logic        obs_v [2];
    logic [31:0] obs_d [2];
    always_comb begin
        obs_v[0] = s1_readdatavalid;
        obs_v[1] = s2_readdatavalid;
        obs_d[0] = s1_readdata;
        obs_d[1] = s2_readdata;
    end

    // Reference model: word array plus per-port list of reads awaiting delivery.
    // A read is delivered after READ_LATENCY clock-enabled edges of its port.
    logic [31:0] mm [32];
    logic        exp_v [2];
    logic [31:0] exp_d [2];
    int          en_cnt [2];
    logic [31:0] pend_d [2][64];
    int          pend_due [2][64];
    int          ph [2];
    int          pt [2];
    int          since_rel;

    task automatic model_edge();
        logic        cs [2], rd [2], wr [2], ck [2];
        logic [4:0]  ad [2];
        logic [3:0]  be [2];
        logic [31:0] wd [2];
        logic [31:0] old;
        bit          run;
        cs[0] = s1_chipselect; rd[0] = s1_read; wr[0] = s1_write; ck[0] = s1_clken;
        ad[0] = s1_address; be[0] = s1_byteenable; wd[0] = s1_writedata;
        cs[1] = s2_chipselect; rd[1] = s2_read; wr[1] = s2_write; ck[1] = s2_clken;
        ad[1] = s2_address; be[1] = s2_byteenable; wd[1] = s2_writedata;
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                exp_v[p] = 1'b0; exp_d[p] = '0; ph[p] = 0; pt[p] = 0; en_cnt[p] = 0;
            end
            since_rel = 0;
            return;
        end
        if (since_rel < 2) since_rel++;
        run = (since_rel >= 2);
        for (int p = 0; p < 2; p++) begin
            old = (int'(ad[p]) < DEPTH) ? mm[ad[p]] : 32'h0;
            if (ck[p]) begin
                en_cnt[p]++;
                exp_v[p] = 1'b0;
                if (cs[p] && run && rd[p] && !wr[p]) begin
                    pend_d[p][pt[p]]   = old;
                    pend_due[p][pt[p]] = en_cnt[p] + RL - 1;
                    pt[p] = (pt[p] + 1) % 64;
                end
                if (ph[p] != pt[p] && pend_due[p][ph[p]] == en_cnt[p]) begin
                    exp_v[p] = 1'b1;
                    exp_d[p] = pend_d[p][ph[p]];
                    ph[p] = (ph[p] + 1) % 64;
                end
            end
        end
        // Port 2 applied first so port 1 takes bytes both enable.
        if (!freeze) begin
            for (int p = 1; p >= 0; p--) begin
                if (cs[p] && ck[p] && run && wr[p] && int'(ad[p]) < DEPTH) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[p][b]) mm[ad[p]][8*b +: 8] = wd[p][8*b +: 8];
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_port(input int p, input logic cs, input logic rd, input logic wr,
                            input logic [4:0] ad, input logic [3:0] be,
                            input logic [31:0] wd, input logic ck);
        if (p == 0) begin
            s1_chipselect = cs; s1_read = rd; s1_write = wr; s1_address = ad;
            s1_byteenable = be; s1_writedata = wd; s1_clken = ck;
        end else begin
            s2_chipselect = cs; s2_read = rd; s2_write = wr; s2_address = ad;
            s2_byteenable = be; s2_writedata = wd; s2_clken = ck;
        end
    endtask

    task automatic idle();
        set_port(0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1);
        set_port(1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1);
        freeze = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        for (int p = 0; p < 32; p++) mm[p] = '0;
        #1;
        checks++;
        if (s1_readdatavalid !== 1'b0 || s2_readdatavalid !== 1'b0 || s1_readdata !== 32'h0 || s2_readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: v1=%b v2=%b d1=%h d2=%h, expected all zero",
                     s1_readdatavalid, s2_readdatavalid, s1_readdata, s2_readdata);
        end
        tick(); tick();
        reset_n = 1'b1;
        set_port(0, 1'b1, 1'b1, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) idle();
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (obs_v[p] !== exp_v[p] || obs_d[p] !== exp_d[p]) begin
                    failures++;
                    $display("FAIL reset_release port%0d: valid=%b data=%h, expected valid=%b data=%h",
                             p + 1, obs_v[p], obs_d[p], exp_v[p], exp_d[p]);
                end
            end
        end
    endtask

    task automatic test_init_fill();
        for (int a = 0; a < DEPTH / 2; a++) begin
            set_port(0, 1'b1, 1'b0, 1'b1, 5'(2*a), 4'hF, $urandom, 1'b1);
            set_port(1, 1'b1, 1'b0, 1'b1, 5'(2*a + 1), 4'hF, $urandom, 1'b1);
            tick();
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (obs_v[p] !== exp_v[p] || obs_d[p] !== exp_d[p]) begin
                    failures++;
                    $display("FAIL init_fill port%0d: valid=%b data=%h, expected valid=%b data=%h",
                             p + 1, obs_v[p], obs_d[p], exp_v[p], exp_d[p]);
                end
            end
        end
        idle();
    endtask

    task automatic test_byteenable();
        idle();
        set_port(0, 1'b1, 1'b0, 1'b1, 5'd3, 4'hF, 32'hA5A5A5A5, 1'b1);
        tick();
        set_port(0, 1'b1, 1'b0, 1'b1, 5'd3, 4'h1, 32'h000000FF, 1'b1);
        tick();
        idle();
        set_port(1, 1'b1, 1'b1, 1'b0, 5'd3, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) idle();
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (obs_v[p] !== exp_v[p] || obs_d[p] !== exp_d[p]) begin
                    failures++;
                    $display("FAIL byteenable port%0d: valid=%b data=%h, expected valid=%b data=%h",
                             p + 1, obs_v[p], obs_d[p], exp_v[p], exp_d[p]);
                end
            end
            checks++;
            if (s2_readdatavalid !== (i == 1) || (i >= 1 && s2_readdata !== 32'hA5A5A5FF)) begin
                failures++;
                $display("FAIL byteenable_word cyc%0d: valid=%b data=%h, expected valid=%b data=a5a5a5ff",
                         i, s2_readdatavalid, s2_readdata, (i == 1));
            end
        end
    endtask

    task automatic test_collision_stream();
        idle();
        set_port(0, 1'b1, 1'b0, 1'b1, 5'd5, 4'b0011, 32'h11111111, 1'b1);
        set_port(1, 1'b1, 1'b0, 1'b1, 5'd5, 4'b1110, 32'h22222222, 1'b1);
        tick();
        idle();
        set_port(0, 1'b1, 1'b1, 1'b0, 5'd5, 4'h0, 32'h0, 1'b1);
        tick();
        idle();
        tick();
        checks++;
        if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h22221111) begin
            failures++;
            $display("FAIL collision: valid=%b data=%h, expected valid=1 data=22221111",
                     s1_readdatavalid, s1_readdata);
        end
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k < 4) set_port(1, 1'b1, 1'b1, 1'b0, 5'(k), 4'h0, 32'h0, 1'b1);
            tick();
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (obs_v[p] !== exp_v[p] || obs_d[p] !== exp_d[p]) begin
                    failures++;
                    $display("FAIL stream port%0d: valid=%b data=%h, expected valid=%b data=%h",
                             p + 1, obs_v[p], obs_d[p], exp_v[p], exp_d[p]);
                end
            end
            checks++;
            if (s2_readdatavalid !== (k >= 1 && k <= 4) || (k >= 1 && k <= 4 && s2_readdata !== mm[k-1])) begin
                failures++;
                $display("FAIL stream_order cyc%0d: valid=%b data=%h", k, s2_readdatavalid, s2_readdata);
            end
        end
    endtask

    task automatic test_read_during_write();
        idle();
        set_port(0, 1'b1, 1'b0, 1'b1, 5'd7, 4'hF, 32'hDEADBEEF, 1'b1);
        tick();
        set_port(0, 1'b1, 1'b0, 1'b1, 5'd7, 4'hF, 32'h0, 1'b1);
        set_port(1, 1'b1, 1'b1, 1'b0, 5'd7, 4'h0, 32'h0, 1'b1);
        tick();
        idle();
        set_port(1, 1'b1, 1'b1, 1'b0, 5'd7, 4'h0, 32'h0, 1'b1);
        // Port 1 read+write together must act as a write with no read return.
        set_port(0, 1'b1, 1'b1, 1'b1, 5'd8, 4'hF, 32'h5A5A5A5A, 1'b1);
        tick();
        idle();
        checks++;
        if (s2_readdatavalid !== 1'b1 || s2_readdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rdw_old: valid=%b data=%h, expected valid=1 data=deadbeef", s2_readdatavalid, s2_readdata);
        end
        set_port(0, 1'b1, 1'b1, 1'b0, 5'd8, 4'h0, 32'h0, 1'b1);
        tick();
        idle();
        checks++;
        if (s2_readdatavalid !== 1'b1 || s2_readdata !== 32'h0 || s1_readdatavalid !== 1'b0) begin
            failures++;
            $display("FAIL rdw_new: v2=%b d2=%h v1=%b, expected v2=1 d2=00000000 v1=0",
                     s2_readdatavalid, s2_readdata, s1_readdatavalid);
        end
        tick();
        checks++;
        if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL rw_as_write: valid=%b data=%h, expected valid=1 data=5a5a5a5a", s1_readdatavalid, s1_readdata);
        end
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_v[p] !== exp_v[p] || obs_d[p] !== exp_d[p]) begin
                failures++;
                $display("FAIL rdw port%0d: valid=%b data=%h, expected valid=%b data=%h",
                         p + 1, obs_v[p], obs_d[p], exp_v[p], exp_d[p]);
            end
        end
    endtask

    task automatic test_freeze_range();
        logic [31:0] old2;
        old2 = mm[2];
        idle();
        freeze = 1'b1;
        set_port(0, 1'b1, 1'b0, 1'b1, 5'd2, 4'hF, 32'h12345678, 1'b1);
        set_port(1, 1'b1, 1'b1, 1'b0, 5'd2, 4'h0, 32'h0, 1'b1);
        tick();
        idle();
        set_port(0, 1'b1, 1'b1, 1'b0, 5'd2, 4'h0, 32'h0, 1'b1);
        set_port(1, 1'b1, 1'b0, 1'b1, 5'd20, 4'hF, 32'hFFFFFFFF, 1'b1);
        tick();
        idle();
        set_port(1, 1'b1, 1'b1, 1'b0, 5'd20, 4'h0, 32'h0, 1'b1);
        set_port(0, 1'b1, 1'b1, 1'b0, 5'd4, 4'h0, 32'h0, 1'b1);
        tick();
        idle();
        checks++;
        if (s1_readdatavalid !== 1'b1 || s1_readdata !== old2) begin
            failures++;
            $display("FAIL freeze: valid=%b data=%h, expected valid=1 data=%h", s1_readdatavalid, s1_readdata, old2);
        end
        set_port(0, 1'b1, 1'b1, 1'b0, 5'd31, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle();
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (obs_v[p] !== exp_v[p] || obs_d[p] !== exp_d[p]) begin
                    failures++;
                    $display("FAIL freeze_range port%0d: valid=%b data=%h, expected valid=%b data=%h",
                             p + 1, obs_v[p], obs_d[p], exp_v[p], exp_d[p]);
                end
            end
            if (i == 0) begin
                checks++;
                if (s2_readdatavalid !== 1'b1 || s2_readdata !== 32'h0 || s1_readdata !== mm[4]) begin
                    failures++;
                    $display("FAIL out_of_range: v2=%b d2=%h d1=%h, expected v2=1 d2=00000000 d1=%h",
                             s2_readdatavalid, s2_readdata, s1_readdata, mm[4]);
                end
            end
        end
    endtask

    task automatic test_stall();
        idle();
        set_port(0, 1'b1, 1'b1, 1'b0, 5'd10, 4'h0, 32'h0, 1'b1);
        set_port(1, 1'b1, 1'b1, 1'b0, 5'd12, 4'h0, 32'h0, 1'b1);
        tick();
        set_port(0, 1'b1, 1'b1, 1'b0, 5'd11, 4'h0, 32'h0, 1'b1);
        set_port(1, 1'b1, 1'b1, 1'b0, 5'd13, 4'h0, 32'h0, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i < 3) begin
                set_port(0, 1'b1, 1'b1, 1'b0, 5'd15, 4'h0, 32'h0, 1'b0);
                set_port(1, 1'b1, 1'b1, 1'b0, 5'(14 + i), 4'h0, 32'h0, 1'b1);
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (obs_v[p] !== exp_v[p] || obs_d[p] !== exp_d[p]) begin
                    failures++;
                    $display("FAIL stall port%0d cyc%0d: valid=%b data=%h, expected valid=%b data=%h",
                             p + 1, i, obs_v[p], obs_d[p], exp_v[p], exp_d[p]);
                end
            end
            checks++;
            if ((i < 3 && (s1_readdatavalid !== 1'b1 || s1_readdata !== mm[10])) ||
                (i == 3 && (s1_readdatavalid !== 1'b1 || s1_readdata !== mm[11])) ||
                (i >= 4 && (s1_readdatavalid !== 1'b0 || s1_readdata !== mm[11]))) begin
                failures++;
                $display("FAIL stall_timing cyc%0d: valid=%b data=%h", i, s1_readdatavalid, s1_readdata);
            end
        end
    endtask

    task automatic test_reset_inflight();
        idle();
        set_port(0, 1'b1, 1'b1, 1'b0, 5'd4, 4'h0, 32'h0, 1'b1);
        tick();
        idle();
        reset_n = 1'b0;
        #1;
        checks++;
        if (s1_readdatavalid !== 1'b0 || s1_readdata !== 32'h0 || s2_readdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: v1=%b d1=%h d2=%h, expected all zero", s1_readdatavalid, s1_readdata, s2_readdata);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (s1_readdatavalid !== 1'b0 || s1_readdata !== 32'h0 || obs_v[1] !== exp_v[1]) begin
                failures++;
                $display("FAIL inflight_discard cyc%0d: v1=%b d1=%h, expected v1=0 d1=00000000", i, s1_readdatavalid, s1_readdata);
            end
        end
    endtask

    task automatic test_release_timing();
        int          pulses;
        logic [31:0] got;
        pulses = 0;
        got    = '0;
        idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_port(0, 1'b1, 1'b1, 1'b0, 5'd6, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) idle();
            tick();
            if (s1_readdatavalid === 1'b1) begin
                pulses++;
                got = s1_readdata;
            end
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (obs_v[p] !== exp_v[p] || obs_d[p] !== exp_d[p]) begin
                    failures++;
                    $display("FAIL release port%0d cyc%0d: valid=%b data=%h, expected valid=%b data=%h",
                             p + 1, i, obs_v[p], obs_d[p], exp_v[p], exp_d[p]);
                end
            end
        end
        checks++;
        if (pulses != 1 || got !== mm[6]) begin
            failures++;
            $display("FAIL release_first_accept: pulses=%0d data=%h, expected pulses=1 data=%h", pulses, got, mm[6]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                set_port(p, ($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0,
                         5'($urandom_range(0, 23)), 4'($urandom), $urandom, ($urandom % 5) != 0);
            end
            freeze = (($urandom % 8) == 0);
            tick();
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (obs_v[p] !== exp_v[p] || obs_d[p] !== exp_d[p]) begin
                    failures++;
                    $display("FAIL random port%0d cyc%0d: valid=%b data=%h, expected valid=%b data=%h",
                             p + 1, i, obs_v[p], obs_d[p], exp_v[p], exp_d[p]);
                end
            end
        end
        idle();
    endtask

    initial begin
        since_rel = 0;
        for (int p = 0; p < 2; p++) begin
            exp_v[p] = 1'b0; exp_d[p] = '0; ph[p] = 0; pt[p] = 0; en_cnt[p] = 0;
        end
        test_reset();
        test_init_fill();
        test_byteenable();
        test_collision_stream();
        test_read_during_write();
        test_freeze_range();
        test_stall();
        test_reset_inflight();
        test_release_timing();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
